// File: rtl/cordic_req_scheduler.sv
// cordic_req_scheduler: shares one pipelined CORDIC core among NUM_REQ requesters with tagged result routing.
// Define CORDIC_SCHED_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module cordic_req_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int CORDIC_WIDTH = 22,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int PIPE_LAT     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_y,
  input  logic [NUM_REQ-1:0]             req_mode,
  output logic                           cor_en,
  output logic [CORDIC_WIDTH-1:0]        cor_x,
  output logic [CORDIC_WIDTH-1:0]        cor_y,
  output logic                           cor_mode,
  input  logic                           cor_res_vld,
  input  logic [CORDIC_WIDTH-1:0]        cor_res_x,
  input  logic [CORDIC_WIDTH-1:0]        cor_res_y,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [CORDIC_WIDTH-1:0]        rsp_x,
  output logic [CORDIC_WIDTH-1:0]        rsp_y,
  output logic                           busy,
  output logic                           flush_done,
  output logic                           tag_err
);
  localparam int CNT_W = $clog2(PIPE_LAT + 1) + 1;
  localparam int PAD   = CORDIC_WIDTH - DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                 state;
  logic [ID_WIDTH-1:0]    ptr, gnt_id, cor_id;
  logic [ID_WIDTH:0]      s;
  logic                   found, prio0, xfer, idle_ok, tag_out, sel_mode;
  logic [NUM_REQ-1:0]     rr_vec;
  logic [DATA_WIDTH-1:0]  sel_x, sel_y;
  logic [CNT_W-1:0]       cnt;
  logic [PIPE_LAT-1:0]    tag_vld;
  logic [ID_WIDTH-1:0]    tag_id [PIPE_LAT];
  // Scan downward so the last hit wins: the first valid requester at or after ptr.
  always_comb begin
`ifdef CORDIC_SCHED_PRIO_EN
    prio0  = req_valid[0];
    rr_vec = req_valid & ~NUM_REQ'(1);
`else
    prio0  = 1'b0;
    rr_vec = req_valid;
`endif
    found  = prio0;
    gnt_id = '0;
    s      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
      s = (s >= (ID_WIDTH + 1)'(NUM_REQ)) ? s - (ID_WIDTH + 1)'(NUM_REQ) : s;
      if (!prio0 && |(rr_vec & (NUM_REQ'(1) << s))) begin
        found  = 1'b1;
        gnt_id = s[ID_WIDTH-1:0];
      end
    end
  end
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_mode = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt_id == ID_WIDTH'(k)) begin
        sel_x    = req_x[k*DATA_WIDTH +: DATA_WIDTH];
        sel_y    = req_y[k*DATA_WIDTH +: DATA_WIDTH];
        sel_mode = req_mode[k];
      end
  end
  assign xfer      = (state == RUN) && enable && !flush && found;
  assign req_ready = xfer ? NUM_REQ'(1) << gnt_id : '0;
  assign tag_out   = tag_vld[PIPE_LAT-1];
  // An op sitting on cor_en is already in flight even though cnt has not counted it yet.
  assign idle_ok   = (cnt == '0) && !cor_en;
  assign busy      = (cnt != '0) || (state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cor_en     <= 1'b0;
      cor_x      <= '0;
      cor_y      <= '0;
      cor_mode   <= 1'b0;
      cor_id     <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      flush_done <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          flush_done <= flush;
          state      <= (enable && !flush) ? RUN : IDLE;
        end
        RUN:
          if (flush) state <= DRAIN;
          else if (!enable) state <= idle_ok ? IDLE : DRAIN;
        default:
          if (idle_ok) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
      endcase
      cor_en <= xfer;
      if (xfer) begin
        cor_x    <= {sel_x, {PAD{1'b0}}};
        cor_y    <= {sel_y, {PAD{1'b0}}};
        cor_mode <= sel_mode;
        cor_id   <= gnt_id;
        if (!prio0) ptr <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
      end
      cnt       <= cnt + CNT_W'(cor_en) - CNT_W'(tag_out);
      rsp_valid <= (tag_out && cor_res_vld) ? NUM_REQ'(1) << tag_id[PIPE_LAT-1] : '0;
      if (tag_out && cor_res_vld) begin
        rsp_x <= cor_res_x;
        rsp_y <= cor_res_y;
      end
      if (tag_out != cor_res_vld) tag_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= cor_en;
      tag_id[0]  <= cor_id;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end
endmodule

// File: tb/tb_cordic_req_scheduler.sv
// tb_cordic_req_scheduler: directed bench with a fixed-latency core model for cordic_req_scheduler.
module tb_cordic_req_scheduler;
  localparam int DW = 16, CW = 22, N = 4, IW = 2, L = 16;
  logic            clk, rst, enable, flush, inj;
  logic [N-1:0]    req_valid, req_ready, req_mode, rsp_valid;
  logic [N*DW-1:0] req_x, req_y;
  logic            cor_en, cor_mode, cor_res_vld, busy, flush_done, tag_err;
  logic [CW-1:0]   cor_x, cor_y, cor_res_x, cor_res_y, rsp_x, rsp_y;
  int n_chk = 0, n_err = 0, cyc = 0, n;
  int gq[$], rq[$], enq[$];
  logic [CW-1:0] rxq[$];
  logic busy_early;
  cordic_req_scheduler #(.DATA_WIDTH(DW), .CORDIC_WIDTH(CW), .NUM_REQ(N), .ID_WIDTH(IW), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .cor_en(cor_en), .cor_x(cor_x), .cor_y(cor_y), .cor_mode(cor_mode),
    .cor_res_vld(cor_res_vld), .cor_res_x(cor_res_x), .cor_res_y(cor_res_y),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy), .flush_done(flush_done), .tag_err(tag_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // Core model: fixed latency L, result x+1 / y-1, never reset so stale results survive rst.
  logic [L-1:0] m_vld = '0;
  logic [CW-1:0] m_x [L];
  logic [CW-1:0] m_y [L];
  always @(posedge clk) begin
    m_vld <= {m_vld[L-2:0], cor_en};
    m_x[0] <= cor_x + 22'd1;
    m_y[0] <= cor_y - 22'd1;
    for (int k = 1; k < L; k++) begin
      m_x[k] <= m_x[k-1];
      m_y[k] <= m_y[k-1];
    end
  end
  assign cor_res_vld = m_vld[L-1] | inj;
  assign cor_res_x   = m_x[L-1];
  assign cor_res_y   = m_y[L-1];
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      for (int k = 0; k < N; k++) if (req_valid[k] && req_ready[k]) gq.push_back(k);
      if (cor_en) enq.push_back(cyc);
      for (int k = 0; k < N; k++) if (rsp_valid[k]) begin
        rq.push_back(k);
        rxq.push_back(rsp_x);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_q();
    gq.delete(); rq.delete(); enq.delete(); rxq.delete();
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1; enable = 0; flush = 0; inj = 0;
    req_valid = '1; req_x = '0; req_y = '0; req_mode = '0;
    step(); step();
    check("rst_cor_en", cor_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_flush_done", flush_done, 0);
    // single request from requester 2
    rst = 0; req_valid = 0; enable = 1;
    step();
    req_valid = 4'b0100; req_mode = 4'b0100;
    req_x = {16'h0, 16'h4000, 32'h0};
    req_y = {16'h0, 16'h8001, 32'h0};
    #1;
    check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = 0;
    check("single_cor_en", cor_en, 1);
    check("single_cor_x", cor_x, 22'h100000);
    check("single_cor_y", cor_y, 22'h200040);
    check("single_cor_mode", cor_mode, 1);
    step();
    check("single_cor_en_drop", cor_en, 0);
    n = 1;
    while (rsp_valid == 0 && n < 40) begin step(); n++; end
    check("single_latency", n, 17);
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_x", rsp_x, 22'h100001);
    check("single_rsp_y", rsp_y, 22'h20003f);
    // saturation: all requesters valid for 12 cycles
    rst = 1; step(); rst = 0; enable = 1; step();
    clear_q();
    req_x = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    req_y = req_x; req_mode = '0; req_valid = '1;
    repeat (12) step();
    req_valid = 0;
    n = 0;
    while (rq.size() < 12 && n < 60) begin step(); n++; end
    check("sat_grant_cnt", gq.size(), 12);
    for (int k = 0; k < 12; k++) check("sat_grant_order", k < gq.size() ? gq[k] : -1, k % 4);
    check("sat_en_cnt", enq.size(), 12);
    check("sat_en_span", enq.size() == 12 ? enq[11] - enq[0] : -1, 11);
    check("sat_rsp_cnt", rq.size(), 12);
    for (int k = 0; k < 12; k++) check("sat_rsp_order", k < rq.size() ? rq[k] : -1, k % 4);
    check("sat_rsp_x0", rxq.size() > 3 ? rxq[0] : '1, 22'h040001);
    check("sat_rsp_x3", rxq.size() > 3 ? rxq[3] : '1, 22'h100001);
    // flush mid-stream after 5 ops
    clear_q();
    req_valid = '1;
    repeat (5) step();
    flush = 1;
    #1;
    check("flush_ready", req_ready, 0);
    step();
    flush = 0; enable = 0; req_valid = 0;
    check("flush_grants", gq.size(), 5);
    check("flush_busy", busy, 1);
    n = 0; busy_early = 0;
    while (!flush_done && n < 60) begin
      if (!busy && rq.size() < 5) busy_early = 1;
      step(); n++;
    end
    check("flush_done_seen", flush_done, 1);
    check("flush_rsp_cnt", rq.size(), 5);
    check("flush_busy_early", busy_early, 0);
    check("flush_busy_after", busy, 0);
    step();
    check("flush_done_pulse", flush_done, 0);
    // flush while idle
    flush = 1; step(); flush = 0;
    check("idle_flush_done", flush_done, 1);
    step();
    check("idle_flush_done_drop", flush_done, 0);
    // result with empty tag pipe
    inj = 1; step(); inj = 0;
    check("tag_err_set", tag_err, 1);
    check("tag_err_no_rsp", rsp_valid, 0);
    repeat (3) step();
    check("tag_err_sticky", tag_err, 1);
    rst = 1; step(); rst = 0;
    check("tag_err_rst", tag_err, 0);
    // reset with three ops in flight
    enable = 1; step();
    req_valid = '1;
    repeat (3) step();
    rst = 1; step();
    check("midrst_cor_en", cor_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_tag_err", tag_err, 0);
    rst = 0; enable = 0; req_valid = 0; rq.delete();
    repeat (20) step();
    check("midrst_no_rsp", rq.size(), 0);
    check("midrst_stale_err", tag_err, 1);
    check("midrst_busy_after", busy, 0);
    // arbitration pattern checks
    rst = 1; step(); rst = 0; enable = 1; step();
    clear_q();
`ifdef CORDIC_SCHED_PRIO_EN
    begin
      int exp_g[8] = '{0, 0, 0, 0, 1, 2, 3, 1};
      req_valid = '1; repeat (4) step();
      req_valid = 4'b1110; repeat (4) step();
      req_valid = 0;
      check("prio_grant_cnt", gq.size(), 8);
      for (int k = 0; k < 8; k++) check("prio_order", k < gq.size() ? gq[k] : -1, exp_g[k]);
    end
`else
    begin
      int exp_g[5] = '{1, 3, 1, 2, 3};
      req_valid = 4'b1010; repeat (3) step();
      req_valid = 4'b1111; repeat (2) step();
      req_valid = 0;
      check("rr_grant_cnt", gq.size(), 5);
      for (int k = 0; k < 5; k++) check("rr_order", k < gq.size() ? gq[k] : -1, exp_g[k]);
    end
`endif
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cordic_req_scheduler.md
Name: cordic_req_scheduler

Overview:
- Shares one pipelined CORDIC core between NUM_REQ requesters (FastICA rotation/normalisation engines).
- Arbitrates operand requests, upscales DATA_WIDTH operands to CORDIC_WIDTH (MSB-aligned, zero-filled LSBs), issues one operation per cycle, and tags each operation with its requester ID.
- Routes results back to the requester that issued them.
- Provides drain/flush sequencing so software can quiesce the core.

Parameters:
- DATA_WIDTH, 16, requester operand width
- CORDIC_WIDTH, 22, core datapath width; must be > DATA_WIDTH
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, requester ID width; must satisfy 2^ID_WIDTH >= NUM_REQ
- PIPE_LAT, 16, fixed core latency in cycles from cor_en to cor_res_vld (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  allow new grants
- flush  in  1  pulse; stop granting and drain in-flight ops
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_x  in  NUM_REQ*DATA_WIDTH  packed x operands; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_y  in  NUM_REQ*DATA_WIDTH  packed y operands
- req_mode  in  NUM_REQ  0=rotation, 1=vectoring
- cor_en  out  1  issue strobe to core
- cor_x  out  CORDIC_WIDTH  upscaled x
- cor_y  out  CORDIC_WIDTH  upscaled y
- cor_mode  out  1  mode of the issued op
- cor_res_vld  in  1  core result valid
- cor_res_x  in  CORDIC_WIDTH  core result x
- cor_res_y  in  CORDIC_WIDTH  core result y
- rsp_valid  out  NUM_REQ  one-hot result strobe
- rsp_x  out  CORDIC_WIDTH  result x (shared bus)
- rsp_y  out  CORDIC_WIDTH  result y (shared bus)
- busy  out  1  in-flight count != 0 or state != IDLE
- flush_done  out  1  one-cycle pulse when drain completes
- tag_err  out  1  sticky: cor_res_vld disagrees with tag pipe

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; in-flight count 0; tag pipe cleared. A reset mid-operation discards all in-flight tags. Results still arriving from the core after reset are ignored but set tag_err.
- States:
  - IDLE -> RUN when enable=1 and flush=0.
  - RUN -> IDLE when enable=0 and in-flight=0.
  - RUN -> DRAIN when flush=1, or when enable=0 with in-flight!=0.
  - DRAIN -> IDLE when in-flight=0; flush_done pulses in that transition cycle.
  - flush in IDLE: flush_done pulses the next cycle.
  - flush has priority over enable.
- Grants only in RUN. req_ready is combinational: it is one-hot on the first i with req_valid[i]=1, searching from the pointer upward with wrap. Transfer occurs when req_valid[i] & req_ready[i].
- On transfer in cycle T:
  - Pointer becomes (i+1) mod NUM_REQ.
  - At T+1 (registered): cor_en=1, cor_x={req_x[i],(CORDIC_WIDTH-DATA_WIDTH) zeros}, same for cor_y, cor_mode=req_mode[i].
  - If there is no transfer, cor_en=0 and cor_x/cor_y/cor_mode hold their values.
- Tag pipe: PIPE_LAT stages of {vld,id}, loaded with {cor_en,id} as cor_en is asserted. The tag for an op issued at cycle E is compared with cor_res_vld at cycle E+PIPE_LAT.
  - Tag valid with cor_res_vld=1: at E+PIPE_LAT+1, rsp_valid[id]=1 and rsp_x/rsp_y are the registered cor_res_x/cor_res_y.
  - Mismatch in either direction: tag_err is set and stays set until rst. No response is emitted for a result without a tag.
- No back-pressure on responses: requesters must accept rsp_valid unconditionally.
- In-flight count (width clog2(PIPE_LAT+1)+1): +1 on cor_en, -1 when the tag leaves the pipe; both in one cycle = unchanged. Count never exceeds PIPE_LAT.
- Throughput: 1 op/cycle sustained; all requesters valid continuously -> strict rotation 0,1,..,NUM_REQ-1,0.

Optional Feature:
- Macro CORDIC_SCHED_PRIO_EN.
- Defined: requester 0 has absolute priority. Whenever req_valid[0]=1 in RUN it is granted, and the pointer is not updated. Requesters 1..NUM_REQ-1 are round-robin among themselves only when req_valid[0]=0.
- Undefined: pure round-robin across all NUM_REQ as described above.

Test Plan:
- Single request: reset, enable=1, requester 2 presents x=16'h4000, y=16'h8001 at T -> cor_en at T+1 with cor_x=22'h100000, cor_y=22'h200040. The model returns the result at T+1+PIPE_LAT -> rsp_valid=4'b0100 one cycle later.
- Saturation: all four req_valid=1 for 12 cycles -> grant order 0,1,2,3 repeated 3 times; 12 consecutive cor_en; in-flight count peaks at 12 with PIPE_LAT=16; responses return in the same order.
- Flush mid-stream: issue 5 ops, pulse flush -> req_ready=0 immediately; busy=1 until the 5th response; flush_done pulses once; state IDLE.
- Tag error: inject cor_res_vld=1 with an empty tag pipe -> tag_err=1, no rsp_valid, tag_err stays set; rst clears it.
- Reset mid-operation: rst with 3 ops in flight -> all outputs 0 next cycle and in-flight=0; stale core results set tag_err only.
- Priority build (CORDIC_SCHED_PRIO_EN): req_valid=4'b1111 held -> requester 0 granted every cycle. Drop req_valid[0] -> grants 1,2,3,1.
